ssd_scan_controller: RTL and testbench

SSD_SCAN_CONTROLLER -- requirements
Module: ssd_scan_controller

---
 rtl/ssd_scan_controller_pkg.sv | 43 ++++
 rtl/ssd_scan_controller_hex_decoder.sv | 15 +
 rtl/ssd_scan_controller.sv | 139 +++++++++++++
 tb/tb_ssd_scan_controller.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the scan state encoding, digit entry layout and segment table.
package ssd_scan_controller_pkg;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [3:0] value;
        logic       dp;
        logic       blank;
    } digit_t;

    // Segment order is {a,b,c,d,e,f,g}, active-low
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Entry n is the pattern for hex digit n
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        return SEG_TABLE[v];
    endfunction

endpackage

// File: rtl/ssd_scan_controller_hex_decoder.sv
// Combinational hex to active-low seven-segment decoder.
// Shared by every display block that shows hex digits.
module ssd_hex_decoder
    import ssd_scan_controller_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Pure table lookup
    always_comb begin
        seg = hex_to_seg(value);
    end

endmodule

// File: rtl/ssd_scan_controller.sv
// Multiplexed seven-segment display scanner with per-digit registers.
// Each digit is shown for a fixed time, followed by optional dead time.
module ssd_scan_controller
    import ssd_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int SHOW_CYCLES      = 125000,
    parameter int BLANK_CYCLES     = 1024,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  wr_blank,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            cathode,
    output logic                  dp,
    output logic [AW-1:0]         digit_idx
);

    localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ?
                             SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST =
        CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
        {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    digit_t                  digits [NUM_DIGITS];
    scan_state_t             state;
    logic [CW-1:0]           cnt;
    logic [AW-1:0]           idx;

    digit_t                  cur;
    logic [6:0]              cur_seg;
    logic [AW-1:0]           idx_next;
    logic [NUM_DIGITS-1:0]   sel;
    logic [NUM_DIGITS-1:0]   anode_on;

    // Digit register file; out-of-range addresses match no entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_addr == AW'(i)) begin
                    digits[i] <= digit_t'{
                        value: wr_data,
                        dp:    wr_dp,
                        blank: wr_blank
                    };
                end
            end
        end
    end

    // Current digit select, one-hot anode mask and next index
    always_comb begin
        cur = '0;
        sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == AW'(i)) begin
                cur    = digits[i];
                sel[i] = 1'b1;
            end
        end
        idx_next = (idx == IDX_LAST) ? '0 : idx + AW'(1);
        anode_on = ANODE_ACTIVE_LOW ? ~sel : sel;
    end

    ssd_hex_decoder u_dec (
        .value (cur.value),
        .seg   (cur_seg)
    );

    // Scan FSM and registered outputs, driven from the pre-edge state
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state     <= ST_SHOW;
            cnt       <= '0;
            idx       <= '0;
            anode     <= ANODE_OFF;
            cathode   <= SEG_OFF;
            dp        <= 1'b1;
            digit_idx <= '0;
        end else begin
            digit_idx <= idx;
            if (state == ST_SHOW) begin
                anode   <= anode_on;
                cathode <= cur.blank ? SEG_OFF : cur_seg;
                dp      <= cur.blank | ~cur.dp;
            end else begin
                anode   <= ANODE_OFF;
                cathode <= SEG_OFF;
                dp      <= 1'b1;
            end

            unique case (state)
                ST_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt <= '0;
                        if (BLANK_CYCLES == 0) begin
                            idx <= idx_next;
                        end else begin
                            state <= ST_BLANK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= ST_SHOW;
                        idx   <= idx_next;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_SHOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Bench for ssd_scan_controller: three instances share one stimulus stream,
// a slot-arithmetic model checks every cycle, literals pin key moments.
module tb_ssd_scan_controller;

    typedef struct packed {
        logic [3:0] v;
        logic       d;
        logic       b;
    } ent_t;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] ca;
        logic       dp;
        logic [1:0] di;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       wr_blank;

    logic [3:0] a_anode;
    logic [6:0] a_cathode;
    logic       a_dp;
    logic [1:0] a_idx;
    logic [2:0] b_anode;
    logic [6:0] b_cathode;
    logic       b_dp;
    logic [1:0] b_idx;
    logic [3:0] c_anode;
    logic [6:0] c_cathode;
    logic       c_dp;
    logic [1:0] c_idx;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ssd_scan_controller #(
        .NUM_DIGITS(4), .SHOW_CYCLES(4), .BLANK_CYCLES(2),
        .ANODE_ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
        .wr_blank(wr_blank), .anode(a_anode), .cathode(a_cathode),
        .dp(a_dp), .digit_idx(a_idx)
    );

    ssd_scan_controller #(
        .NUM_DIGITS(3), .SHOW_CYCLES(4), .BLANK_CYCLES(2),
        .ANODE_ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
        .wr_blank(wr_blank), .anode(b_anode), .cathode(b_cathode),
        .dp(b_dp), .digit_idx(b_idx)
    );

    ssd_scan_controller #(
        .NUM_DIGITS(4), .SHOW_CYCLES(4), .BLANK_CYCLES(0),
        .ANODE_ACTIVE_LOW(1'b1)
    ) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
        .wr_blank(wr_blank), .anode(c_anode), .cathode(c_cathode),
        .dp(c_dp), .digit_idx(c_idx)
    );

    logic [6:0] seg_ref [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [3:0] seq_an [24] = '{
        4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF,
        4'hD, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF,
        4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF,
        4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF
    };

    ent_t sh_a [4];
    ent_t sh_b [4];
    ent_t sh_c [4];
    exp_t ex_a, ex_b, ex_c;
    int   t     = 0;
    bit   armed = 1'b0;

    // tt < 0 means scanning is stopped; otherwise tt counts enabled edges
    function automatic exp_t predict(input int n, input int s,
                                     input int b, input int tt,
                                     input ent_t e [4]);
        exp_t r;
        int   p, pos, d, w;
        r.an = 8'hFF;
        r.ca = 7'h7F;
        r.dp = 1'b1;
        r.di = 2'd0;
        if (tt >= 0) begin
            p    = s + b;
            pos  = tt % (p * n);
            d    = pos / p;
            w    = pos % p;
            r.di = 2'(d);
            if (w < s) begin
                r.an[d] = 1'b0;
                if (!e[d].b) begin
                    r.ca = seg_ref[e[d].v];
                    r.dp = ~e[d].d;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0h expected %0h",
                      name, $time, act, exp);
    endtask

    // Model: expectations use register contents before this edge
    initial begin
        int tt;
        for (int i = 0; i < 4; i++) begin
            sh_a[i] = '0;
            sh_b[i] = '0;
            sh_c[i] = '0;
        end
        forever begin
            @(posedge clk);
            tt   = (reset || !enable) ? -1 : t;
            ex_a = predict(4, 4, 2, tt, sh_a);
            ex_b = predict(3, 4, 2, tt, sh_b);
            ex_c = predict(4, 4, 0, tt, sh_c);
            if (reset) begin
                for (int i = 0; i < 4; i++) begin
                    sh_a[i] = '0;
                    sh_b[i] = '0;
                    sh_c[i] = '0;
                end
            end else if (wr_en) begin
                sh_a[wr_addr] = '{v: wr_data, d: wr_dp, b: wr_blank};
                sh_c[wr_addr] = '{v: wr_data, d: wr_dp, b: wr_blank};
                if (wr_addr < 2'd3)
                    sh_b[wr_addr] = '{v: wr_data, d: wr_dp, b: wr_blank};
            end
            t     = (reset || !enable) ? 0 : t + 1;
            armed = 1'b1;
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("a_anode", 32'(a_anode), 32'(ex_a.an[3:0]));
                chk("a_cathode", 32'(a_cathode), 32'(ex_a.ca));
                chk("a_dp", 32'(a_dp), 32'(ex_a.dp));
                chk("a_idx", 32'(a_idx), 32'(ex_a.di));
                chk("b_anode", 32'(b_anode), 32'(ex_b.an[2:0]));
                chk("b_cathode", 32'(b_cathode), 32'(ex_b.ca));
                chk("b_dp", 32'(b_dp), 32'(ex_b.dp));
                chk("b_idx", 32'(b_idx), 32'(ex_b.di));
                chk("c_anode", 32'(c_anode), 32'(ex_c.an[3:0]));
                chk("c_cathode", 32'(c_cathode), 32'(ex_c.ca));
                chk("c_dp", 32'(c_dp), 32'(ex_c.dp));
                chk("c_idx", 32'(c_idx), 32'(ex_c.di));
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [3:0] v,
                      input logic d, input logic b);
        wr_en    = 1'b1;
        wr_addr  = a;
        wr_data  = v;
        wr_dp    = d;
        wr_blank = b;
        @(negedge clk);
        wr_en    = 1'b0;
    endtask

    logic [6:0] cat_lit [4] = '{
        7'b1001111, 7'b0001000, 7'b0111000, 7'b0000000
    };

    // Directed stimulus with literal expectations
    initial begin
        int k;
        reset    = 1'b1;
        enable   = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = 4'd0;
        wr_dp    = 1'b0;
        wr_blank = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_anode", 32'(a_anode), 32'h0000000F);
        chk("rst_cathode", 32'(a_cathode), 32'h0000007F);
        chk("rst_dp", 32'(a_dp), 32'h1);
        chk("rst_idx", 32'(a_idx), 32'h0);
        reset = 1'b0;

        wr(2'd0, 4'h1, 1'b0, 1'b0);
        wr(2'd1, 4'hA, 1'b0, 1'b0);
        wr(2'd2, 4'hF, 1'b0, 1'b0);
        wr(2'd3, 4'h8, 1'b0, 1'b0);
        chk("dis_anode", 32'(a_anode), 32'h0000000F);
        enable = 1'b1;

        for (int j = 0; j < 26; j++) begin
            @(negedge clk);
            k = j % 24;
            chk("seq_anode", 32'(a_anode), 32'(seq_an[k]));
            if (seq_an[k] != 4'hF)
                chk("seq_cathode", 32'(a_cathode), 32'(cat_lit[k / 6]));
            if (j == 0)
                chk("n3_cathode0", 32'(b_cathode), 32'(7'b1001111));
            if (j == 3)
                chk("nob_anode3", 32'(c_anode), 32'h0000000E);
            if (j == 4)
                chk("nob_anode4", 32'(c_anode), 32'h0000000D);
        end

        repeat (12) @(negedge clk);
        chk("mid2_anode", 32'(a_anode), 32'h0000000B);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_anode", 32'(a_anode), 32'h0000000F);
        chk("drop_idx", 32'(a_idx), 32'h0);

        wr(2'd2, 4'hF, 1'b1, 1'b1);
        wr(2'd1, 4'hA, 1'b1, 1'b0);
        enable = 1'b1;

        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            chk("re_anode", 32'(a_anode), 32'(seq_an[j]));
            if (seq_an[j] == 4'hD) begin
                chk("s1_dp", 32'(a_dp), 32'h0);
                chk("s1_cathode", 32'(a_cathode), 32'(7'b0001000));
            end
            if (seq_an[j] == 4'hB) begin
                chk("s2_cathode", 32'(a_cathode), 32'h0000007F);
                chk("s2_dp", 32'(a_dp), 32'h1);
            end
        end

        repeat (19) @(negedge clk);
        chk("s3_cathode_pre", 32'(a_cathode), 32'(7'b0000000));
        wr_en    = 1'b1;
        wr_addr  = 2'd3;
        wr_data  = 4'h5;
        wr_dp    = 1'b0;
        wr_blank = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        chk("s3_cathode_k", 32'(a_cathode), 32'(7'b0000000));
        @(negedge clk);
        chk("s3_cathode_k1", 32'(a_cathode), 32'(7'b0100100));
        chk("s3_anode_k1", 32'(a_anode), 32'h00000007);

        repeat (2) @(negedge clk);
        chk("blank_anode", 32'(a_anode), 32'h0000000F);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_anode", 32'(a_anode), 32'h0000000F);
        chk("mrst_cathode", 32'(a_cathode), 32'h0000007F);
        chk("mrst_dp", 32'(a_dp), 32'h1);
        chk("mrst_idx", 32'(a_idx), 32'h0);
        reset = 1'b0;

        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            chk("post_anode", 32'(a_anode), 32'(seq_an[j]));
            if (seq_an[j] != 4'hF)
                chk("post_cathode", 32'(a_cathode), 32'(7'b0000001));
            chk("post_dp", 32'(a_dp), 32'h1);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
